switch_allocator: RTL and testbench
===================================

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 Parameter CHANNEL_NUMBER, default 5, number of router ports; port 0=local, 1=north, 2=east, 3=south, 4=west.
REQ-002 Parameter CHANNEL_NUMBER_WIDTH, default $clog2(CHANNEL_NUMBER), port index width.
REQ-003 Parameters MAX_ROUTERS_X / MAX_ROUTERS_Y, default 4 / 4, mesh size; X_WIDTH/Y_WIDTH = $clog2 of each.
REQ-004 Parameters ROUTER_X / ROUTER_Y, default 0 / 0, this router's mesh coordinates.
REQ-005 clk_i  input  1  single clock, rising edge.
REQ-006 rst_n_i  input  1  asynchronous active-low reset.
REQ-007 in_valid_i  input  CHANNEL_NUMBER  per-input beat valid (TVALID).
REQ-008 in_header_i  input  CHANNEL_NUMBER  per-input current beat is a routing header.
REQ-009 in_dest_x_i  input  [CHANNEL_NUMBER][X_WIDTH]  header target X.
REQ-010 in_dest_y_i  input  [CHANNEL_NUMBER][Y_WIDTH]  header target Y.
REQ-011 in_length_i  input  [CHANNEL_NUMBER][8]  header packet length in beats, header included.
REQ-012 in_beat_done_i  input  CHANNEL_NUMBER  per-input beat accepted (TVALID & TREADY).
REQ-013 out_lock_o  output  CHANNEL_NUMBER  output port o is allocated.
REQ-014 out_sel_o  output  [CHANNEL_NUMBER][CHANNEL_NUMBER_WIDTH]  input index driving output o.
REQ-015 in_grant_o  output  CHANNEL_NUMBER  input i owns some output.
REQ-016 in_port_o  output  [CHANNEL_NUMBER][CHANNEL_NUMBER_WIDTH]  output index owned by input i.

Function
REQ-017 Route per input, combinational XY: dest_x>ROUTER_X -> east; dest_x<ROUTER_X -> west; else dest_y>ROUTER_Y -> north; dest_y<ROUTER_Y -> south; else local.
REQ-018 Input i requests output o when in_valid_i[i] & in_header_i[i] & !in_grant_o[i] & route(i)==o.
REQ-019 Per output, two-state FSM: IDLE, LOCKED.
REQ-020 IDLE with >=1 request: winner = first requester at or after rr_ptr[o], scanning upward with wrap modulo CHANNEL_NUMBER; FSM -> LOCKED next edge.
REQ-021 On grant: out_sel_o[o]=winner, beats_left[o]=in_length_i[winner] (0 loaded as 1), visible the cycle after the request (1-cycle latency).
REQ-022 Outputs only sample requests in IDLE; since an input routes to one output, at most one output grants a given input per cycle.
REQ-023 LOCKED: each cycle with in_beat_done_i[out_sel_o[o]]=1, beats_left[o] decrements by 1; beat_done on other inputs ignored.
REQ-024 LOCKED with beats_left==1 and beat_done: -> IDLE next edge, rr_ptr[o]=(sel+1) mod CHANNEL_NUMBER (wrap CHANNEL_NUMBER-1 -> 0).
REQ-025 Output spends at least one cycle in IDLE after release; no back-to-back regrant same edge.
REQ-026 LOCKED, no beat_done: state, sel, beats_left hold indefinitely (no timeout).
REQ-027 in_grant_o[i]=1 iff some output is LOCKED with out_sel_o==i; in_port_o[i]=that output index, else 0.
REQ-028 out_sel_o[o] holds its last value in IDLE; consumers qualify with out_lock_o.
REQ-029 U-turn (route equal to arrival port) allowed, no special handling.
REQ-030 beats_left is 8-bit unsigned; max packet 255 beats; never underflows.

Reset
REQ-031 rst_n_i low asynchronously forces all FSMs IDLE, out_lock_o=0, out_sel_o=0, beats_left=0, rr_ptr=0, in_grant_o=0, in_port_o=0.
REQ-032 Reset mid-packet drops all allocations; after release first grant follows REQ-020 with rr_ptr=0.
REQ-033 Outputs held at reset values while rst_n_i low; normal operation from first edge after deassertion.

Verification
REQ-034 ROUTER=(1,1); input 0 header dest (3,1) len 3 -> cycle+1 out_lock_o[2]=1, out_sel_o[2]=0, in_port_o[0]=2; after 3 beat_done on input 0 -> out_lock_o[2]=0.
REQ-035 Inputs 1,3,4 all headers to local, continuous -> grants to 1, then 3, then 4, then 1 (rr order), each with 1-cycle IDLE gap.
REQ-036 Inputs 0 and 1 headers to east and north same cycle -> both outputs lock same cycle, in_grant_o=0b00011.
REQ-037 Length 0 header -> locks, releases after exactly one beat_done; length 255 -> releases after 255.
REQ-038 Locked output, beat_done stalled 10 cycles then resumed -> beats_left holds, release count unchanged.
REQ-039 rst_n_i pulsed low between edges mid-packet -> all outputs 0 immediately, pending request regranted after deassertion.

Source files
------------

// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator for a 2D-mesh router with XY routing.
// Each output locks onto one input for a whole packet and releases after its last beat.
module switch_allocator #(
    parameter int unsigned CHANNEL_NUMBER       = 5,
    parameter int unsigned CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
    parameter int unsigned MAX_ROUTERS_X        = 4,
    parameter int unsigned MAX_ROUTERS_Y        = 4,
    parameter int unsigned ROUTER_X             = 0,
    parameter int unsigned ROUTER_Y             = 0
) (
    input  logic                                                 clk_i,
    input  logic                                                 rst_n_i,
    input  logic [CHANNEL_NUMBER-1:0]                            in_valid_i,
    input  logic [CHANNEL_NUMBER-1:0]                            in_header_i,
    input  logic [CHANNEL_NUMBER-1:0][$clog2(MAX_ROUTERS_X)-1:0] in_dest_x_i,
    input  logic [CHANNEL_NUMBER-1:0][$clog2(MAX_ROUTERS_Y)-1:0] in_dest_y_i,
    input  logic [CHANNEL_NUMBER-1:0][7:0]                       in_length_i,
    input  logic [CHANNEL_NUMBER-1:0]                            in_beat_done_i,
    output logic [CHANNEL_NUMBER-1:0]                            out_lock_o,
    output logic [CHANNEL_NUMBER-1:0][CHANNEL_NUMBER_WIDTH-1:0]  out_sel_o,
    output logic [CHANNEL_NUMBER-1:0]                            in_grant_o,
    output logic [CHANNEL_NUMBER-1:0][CHANNEL_NUMBER_WIDTH-1:0]  in_port_o
);

    localparam int unsigned X_WIDTH = $clog2(MAX_ROUTERS_X);
    localparam int unsigned Y_WIDTH = $clog2(MAX_ROUTERS_Y);
    localparam int unsigned CW      = CHANNEL_NUMBER_WIDTH;
    localparam int unsigned LEN_W   = 8;

    localparam logic [CW-1:0] PORT_LOCAL = CW'(0);
    localparam logic [CW-1:0] PORT_NORTH = CW'(1);
    localparam logic [CW-1:0] PORT_EAST  = CW'(2);
    localparam logic [CW-1:0] PORT_SOUTH = CW'(3);
    localparam logic [CW-1:0] PORT_WEST  = CW'(4);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [CHANNEL_NUMBER-1:0]                 state_q, state_d;
    logic [CHANNEL_NUMBER-1:0][CW-1:0]         sel_q, sel_d;
    logic [CHANNEL_NUMBER-1:0][LEN_W-1:0]      beats_q, beats_d;
    logic [CHANNEL_NUMBER-1:0][CW-1:0]         rr_q, rr_d;
    logic [CHANNEL_NUMBER-1:0]                 grant_d;
    logic [CHANNEL_NUMBER-1:0][CW-1:0]         port_d;
    logic [CHANNEL_NUMBER-1:0][CW-1:0]         route;
    logic [CHANNEL_NUMBER-1:0][CHANNEL_NUMBER-1:0] req;
    logic [CHANNEL_NUMBER-1:0]                 found;
    logic [CHANNEL_NUMBER-1:0][CW-1:0]         winner;

    // (p + k) modulo CHANNEL_NUMBER, with p < CHANNEL_NUMBER and k <= CHANNEL_NUMBER
    function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] p, input int unsigned k);
        int unsigned s;
        s = 32'(p) + k;
        if (s >= CHANNEL_NUMBER) begin
            s = s - CHANNEL_NUMBER;
        end
        return CW'(s);
    endfunction

    // XY dimension-order routing: resolve X first, then Y, else eject locally
    always_comb begin
        route = '0;
        for (int unsigned i = 0; i < CHANNEL_NUMBER; i++) begin
            if (in_dest_x_i[i] > X_WIDTH'(ROUTER_X)) begin
                route[i] = PORT_EAST;
            end else if (in_dest_x_i[i] < X_WIDTH'(ROUTER_X)) begin
                route[i] = PORT_WEST;
            end else if (in_dest_y_i[i] > Y_WIDTH'(ROUTER_Y)) begin
                route[i] = PORT_NORTH;
            end else if (in_dest_y_i[i] < Y_WIDTH'(ROUTER_Y)) begin
                route[i] = PORT_SOUTH;
            end else begin
                route[i] = PORT_LOCAL;
            end
        end
    end

    // Request matrix; an input already holding an output cannot ask again
    always_comb begin
        req = '0;
        for (int unsigned o = 0; o < CHANNEL_NUMBER; o++) begin
            for (int unsigned i = 0; i < CHANNEL_NUMBER; i++) begin
                req[o][i] = in_valid_i[i] & in_header_i[i] & ~in_grant_o[i]
                            & (route[i] == CW'(o));
            end
        end
    end

    // Round-robin pick: first requester at or after rr pointer
    always_comb begin
        found  = '0;
        winner = '0;
        for (int unsigned o = 0; o < CHANNEL_NUMBER; o++) begin
            for (int unsigned k = 0; k < CHANNEL_NUMBER; k++) begin
                if (!found[o] && req[o][wrap_add(rr_q[o], k)]) begin
                    found[o]  = 1'b1;
                    winner[o] = wrap_add(rr_q[o], k);
                end
            end
        end
    end

    // Per-output FSM next state
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        beats_d = beats_q;
        rr_d    = rr_q;
        for (int unsigned o = 0; o < CHANNEL_NUMBER; o++) begin
            case (state_q[o])
                IDLE: begin
                    if (found[o]) begin
                        state_d[o] = LOCKED;
                        sel_d[o]   = winner[o];
                        beats_d[o] = (in_length_i[winner[o]] == 8'd0) ? 8'd1
                                                                      : in_length_i[winner[o]];
                    end
                end
                LOCKED: begin
                    if (in_beat_done_i[sel_q[o]]) begin
                        if (beats_q[o] <= 8'd1) begin
                            state_d[o] = IDLE;
                            beats_d[o] = 8'd0;
                            rr_d[o]    = wrap_add(sel_q[o], 1);
                        end else begin
                            beats_d[o] = beats_q[o] - 8'd1;
                        end
                    end
                end
                default: state_d[o] = IDLE;
            endcase
        end
    end

    // Inverse map (input -> owned output) from next-state so it registers in step
    always_comb begin
        grant_d = '0;
        port_d  = '0;
        for (int unsigned o = 0; o < CHANNEL_NUMBER; o++) begin
            if (state_d[o] == LOCKED) begin
                grant_d[sel_d[o]] = 1'b1;
                port_d[sel_d[o]]  = CW'(o);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= '0;
            sel_q      <= '0;
            beats_q    <= '0;
            rr_q       <= '0;
            in_grant_o <= '0;
            in_port_o  <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            beats_q    <= beats_d;
            rr_q       <= rr_d;
            in_grant_o <= grant_d;
            in_port_o  <= port_d;
        end
    end

    assign out_lock_o = state_q;
    assign out_sel_o  = sel_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator with the router placed at mesh position (1,1).
module tb_switch_allocator;

    logic             clk;
    logic             rst_n;
    logic [4:0]       in_valid;
    logic [4:0]       in_header;
    logic [4:0][1:0]  dest_x;
    logic [4:0][1:0]  dest_y;
    logic [4:0][7:0]  length;
    logic [4:0]       beat_done;
    logic [4:0]       out_lock;
    logic [4:0][2:0]  out_sel;
    logic [4:0]       in_grant;
    logic [4:0][2:0]  in_port;

    int n_checks = 0;
    int n_errors = 0;

    switch_allocator #(
        .CHANNEL_NUMBER(5), .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4),
        .ROUTER_X(1), .ROUTER_Y(1)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .in_valid_i     (in_valid),
        .in_header_i    (in_header),
        .in_dest_x_i    (dest_x),
        .in_dest_y_i    (dest_y),
        .in_length_i    (length),
        .in_beat_done_i (beat_done),
        .out_lock_o     (out_lock),
        .out_sel_o      (out_sel),
        .in_grant_o     (in_grant),
        .in_port_o      (in_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hdr(input int i, input int x, input int y, input int l);
        in_valid[i]  = 1'b1;
        in_header[i] = 1'b1;
        dest_x[i]    = 2'(x);
        dest_y[i]    = 2'(y);
        length[i]    = 8'(l);
    endtask

    task automatic clr_all();
        in_valid  = '0;
        in_header = '0;
        dest_x    = '0;
        dest_y    = '0;
        length    = '0;
        beat_done = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr_all();
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clr_all();
        step();
        check("rst_lock",  32'(out_lock), 32'h0);
        check("rst_grant", 32'(in_grant), 32'h0);
        check("rst_sel",   32'(out_sel),  32'h0);
        check("rst_port",  32'(in_port),  32'h0);
        step();
        rst_n = 1'b1;

        // Single packet to east, length 3
        hdr(0, 3, 1, 3);
        check("east_latency", 32'(out_lock), 32'h0);
        step();
        check("east_lock",  32'(out_lock),   32'b00100);
        check("east_sel",   32'(out_sel[2]), 32'd0);
        check("east_port",  32'(in_port[0]), 32'd2);
        check("east_grant", 32'(in_grant),   32'b00001);
        clr_all();
        beat_done[0] = 1'b1;
        step();
        step();
        check("east_hold2", 32'(out_lock), 32'b00100);
        step();
        check("east_rel",       32'(out_lock), 32'h0);
        check("east_rel_grant", 32'(in_grant), 32'h0);
        do_reset();

        // Round robin on local output among inputs 1,3,4
        hdr(1, 1, 1, 1);
        hdr(3, 1, 1, 1);
        hdr(4, 1, 1, 1);
        beat_done = 5'b11010;
        step();
        check("rr_g1_lock", 32'(out_lock[0]), 32'd1);
        check("rr_g1_sel",  32'(out_sel[0]),  32'd1);
        step();
        check("rr_gap1", 32'(out_lock[0]), 32'd0);
        step();
        check("rr_g2_lock", 32'(out_lock[0]), 32'd1);
        check("rr_g2_sel",  32'(out_sel[0]),  32'd3);
        step();
        check("rr_gap2", 32'(out_lock[0]), 32'd0);
        step();
        check("rr_g3_sel", 32'(out_sel[0]), 32'd4);
        check("rr_g3_port", 32'(in_port[4]), 32'd0);
        step();
        check("rr_gap3", 32'(out_lock[0]), 32'd0);
        step();
        check("rr_g4_lock", 32'(out_lock[0]), 32'd1);
        check("rr_g4_sel",  32'(out_sel[0]),  32'd1);
        do_reset();

        // Two independent outputs grant in the same cycle
        hdr(0, 2, 1, 4);
        hdr(1, 1, 2, 4);
        step();
        check("dual_lock",  32'(out_lock),   32'b00110);
        check("dual_grant", 32'(in_grant),   32'b00011);
        check("dual_port0", 32'(in_port[0]), 32'd2);
        check("dual_port1", 32'(in_port[1]), 32'd1);
        check("dual_sel1",  32'(out_sel[1]), 32'd1);
        do_reset();

        // Length 0 behaves as a single-beat packet
        hdr(2, 1, 0, 0);
        step();
        check("len0_lock", 32'(out_lock), 32'b01000);
        check("len0_sel",  32'(out_sel[3]), 32'd2);
        clr_all();
        beat_done[2] = 1'b1;
        step();
        check("len0_rel", 32'(out_lock), 32'h0);
        beat_done = '0;

        // Length 255 with a 10-cycle stall in the middle
        hdr(4, 0, 1, 255);
        step();
        check("len255_lock", 32'(out_lock), 32'b10000);
        check("len255_sel",  32'(out_sel[4]), 32'd4);
        clr_all();
        beat_done = 5'b10000;
        repeat (100) step();
        check("len255_mid", 32'(out_lock[4]), 32'd1);
        beat_done = 5'b01111;
        repeat (10) step();
        check("stall_lock", 32'(out_lock[4]), 32'd1);
        check("stall_grant", 32'(in_grant), 32'b10000);
        beat_done = 5'b10000;
        repeat (154) step();
        check("len255_254", 32'(out_lock[4]), 32'd1);
        step();
        check("len255_rel", 32'(out_lock[4]), 32'd0);
        do_reset();

        // Asynchronous reset mid-packet, pending request regranted afterwards
        hdr(0, 3, 1, 5);
        hdr(3, 3, 2, 2);
        step();
        check("arst_pre_sel", 32'(out_sel[2]), 32'd0);
        in_valid[0]  = 1'b0;
        in_header[0] = 1'b0;
        beat_done[0] = 1'b1;
        step();
        beat_done = '0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_lock",  32'(out_lock), 32'h0);
        check("arst_grant", 32'(in_grant), 32'h0);
        check("arst_sel",   32'(out_sel),  32'h0);
        check("arst_port",  32'(in_port),  32'h0);
        #2 rst_n = 1'b1;
        step();
        check("arst_regrant_lock",  32'(out_lock),   32'b00100);
        check("arst_regrant_sel",   32'(out_sel[2]), 32'd3);
        check("arst_regrant_grant", 32'(in_grant),   32'b01000);
        check("arst_regrant_port",  32'(in_port[3]), 32'd2);
        clr_all();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
